// File: rtl/seg_display_ctrl.sv
// Seven-segment display controller: shadowed display inputs, per-digit static drive,
// and a multiplexed scan bus with blink and leading-zero suppression.
module seg_display_ctrl #(
  parameter int DIGITS    = 2,
  parameter int SCAN_DIV  = 12000,
  parameter int BLINK_DIV = 3000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank,
  input  logic [DIGITS-1:0]     blink,
  input  logic                  lz_en,
  output logic [9*DIGITS-1:0]   seg_led,
  output logic [7:0]            seg_scan,
  output logic [DIGITS-1:0]     dig_n
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SCW   = $clog2(SCAN_DIV);
  localparam int BKW   = $clog2(BLINK_DIV);
  localparam logic [DIGITS-1:0] DIG_ONE = DIGITS'(1);

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h3F;  4'h1: seg = 7'h06;  4'h2: seg = 7'h5B;  4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;  4'h5: seg = 7'h6D;  4'h6: seg = 7'h7D;  4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;  4'h9: seg = 7'h6F;  4'hA: seg = 7'h77;  4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;  4'hD: seg = 7'h5E;  4'hE: seg = 7'h79;  default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  function automatic logic [7:0] mask_digit(input logic [3:0] nib, input logic dp_bit,
                                            input logic dark);
    return dark ? 8'h00 : {dp_bit, hex_to_seg(nib)};
  endfunction

  logic [4*DIGITS-1:0] data_p0;
  logic [DIGITS-1:0]   dp_p0;
  logic [DIGITS-1:0]   blank_p0;
  logic [DIGITS-1:0]   blink_p0;
  logic                lz_en_p0;
  logic [SCW-1:0]      scan_cnt;
  logic [IDX_W-1:0]    idx;
  logic [BKW-1:0]      blink_cnt;
  logic                blink_phase;
  logic [DIGITS-1:0]   sup;
  logic                run_zero;
  logic [7:0]          dig_seg [DIGITS];

  // Stage p0: shadow capture of every display input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_p0  <= '0;
      dp_p0    <= '0;
      blank_p0 <= '1;
      blink_p0 <= '0;
      lz_en_p0 <= 1'b0;
    end else if (load) begin
      data_p0  <= data;
      dp_p0    <= dp;
      blank_p0 <= blank;
      blink_p0 <= blink;
      lz_en_p0 <= lz_en;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt    <= '0;
      idx         <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else begin
      if (scan_cnt == SCW'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        idx      <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      if (blink_cnt == BKW'(BLINK_DIV - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // Suppression runs from the top digit down while nibbles stay zero; blanking does not
  // interrupt the run, and digit 0 is always shown.
  always_comb begin
    run_zero = 1'b1;
    sup      = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      run_zero = run_zero && (data_p0[4*i +: 4] == 4'h0);
      sup[i]   = lz_en_p0 && run_zero;
    end
    for (int i = 0; i < DIGITS; i++) begin
      dig_seg[i] = mask_digit(data_p0[4*i +: 4], dp_p0[i],
                              blank_p0[i] || (blink_p0[i] && !blink_phase) || sup[i]);
    end
  end

  // Stage p1: registered static and multiplexed outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_led  <= '0;
      seg_scan <= 8'h00;
      dig_n    <= '1;
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        seg_led[9*i +: 9] <= {1'b0, dig_seg[i]};
      end
      seg_scan <= dig_seg[idx];
      dig_n    <= ~(DIG_ONE << idx);
    end
  end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Scoreboard bench for seg_display_ctrl (DIGITS=2, SCAN_DIV=4, BLINK_DIV=8).
module tb_seg_display_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [7:0]  data;
  logic [1:0]  dp, blank, blink;
  logic        lz_en;
  logic [17:0] seg_led;
  logic [7:0]  seg_scan;
  logic [1:0]  dig_n;

  seg_display_ctrl #(.DIGITS(2), .SCAN_DIV(4), .BLINK_DIV(8)) dut (
    .clk(clk), .rst(rst), .load(load), .data(data), .dp(dp), .blank(blank),
    .blink(blink), .lz_en(lz_en), .seg_led(seg_led), .seg_scan(seg_scan), .dig_n(dig_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    int          sel;
    logic [17:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic fin_req = 1'b0;
  logic fin_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares every expectation whose due cycle has arrived.
  always @(negedge clk) begin
    exp_t        e;
    logic [17:0] act;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e   = sb.pop_front();
      act = (e.sel == 0) ? seg_led : (e.sel == 1) ? {16'b0, dig_n} : {10'b0, seg_scan};
      checks++;
      if (act !== e.exp || e.due != cyc) begin
        errors++;
        $display("FAIL %s cyc %0d actual %h required %h", e.name, cyc, act, e.exp);
      end
    end
    if (fin_req && !fin_done) begin
      fin_done = 1'b1;
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL leftover_expectations actual %0d required 0", sb.size());
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push(input string name, input int sel, input int due, input logic [17:0] val);
    exp_t e;
    e.due = due; e.sel = sel; e.exp = val; e.name = name;
    sb.push_back(e);
  endtask

  task automatic push_reset(input string name);
    push({name, "_seg_led"}, 0, cyc, 18'h0);
    push({name, "_dig_n"}, 1, cyc, 18'h3);
    push({name, "_seg_scan"}, 2, cyc, 18'h0);
  endtask

  task automatic load_check(input string name, input logic [7:0] d, input logic [1:0] p,
                            input logic [1:0] bl, input logic lz, input logic [17:0] val);
    data = d; dp = p; blank = bl; blink = 2'b00; lz_en = lz; load = 1'b1;
    push(name, 0, cyc + 2, val);
    step(1);
    load = 1'b0;
    step(2);
  endtask

  localparam logic [7:0] SCAN_TAB [16] = '{8'h00, 8'h77, 8'h77, 8'h77, 8'h4F, 8'h4F, 8'h4F, 8'h4F,
                                          8'h77, 8'h77, 8'h77, 8'h77, 8'h6F, 8'h6F, 8'h6F, 8'h6F};
  localparam logic [1:0] DIG_TAB [16]  = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01,
                                          2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01};

  initial begin
    int c0;
    rst = 1'b1; load = 1'b0; data = 8'h00; dp = 2'b00; blank = 2'b00; blink = 2'b00; lz_en = 1'b0;
    step(2);
    push_reset("reset_init");
    step(1);
    rst = 1'b0;

    load_check("load_3A_dp01", 8'h3A, 2'b01, 2'b00, 1'b0, {9'h04F, 9'h0F7});
    load_check("lz_05",        8'h05, 2'b00, 2'b00, 1'b1, {9'h000, 9'h06D});
    load_check("lz_00",        8'h00, 2'b00, 2'b00, 1'b1, {9'h000, 9'h03F});
    load_check("lz_50",        8'h50, 2'b00, 2'b00, 1'b1, {9'h06D, 9'h03F});
    load_check("lz_off_05",    8'h05, 2'b00, 2'b00, 1'b0, {9'h03F, 9'h06D});
    load_check("dec_E7",       8'hE7, 2'b00, 2'b00, 1'b0, {9'h079, 9'h007});
    load_check("dec_Cd",       8'hCD, 2'b00, 2'b00, 1'b0, {9'h039, 9'h05E});
    load_check("dec_8b",       8'h8B, 2'b00, 2'b00, 1'b0, {9'h07F, 9'h07C});
    load_check("dec_12",       8'h12, 2'b00, 2'b00, 1'b0, {9'h006, 9'h05B});
    load_check("dec_46",       8'h46, 2'b00, 2'b00, 1'b0, {9'h066, 9'h07D});
    load_check("dec_9F",       8'h9F, 2'b00, 2'b00, 1'b0, {9'h06F, 9'h071});
    load_check("blank_dp",     8'h3A, 2'b11, 2'b01, 1'b0, {9'h0CF, 9'h000});

    // Inputs change without load: shadow must hold.
    data = 8'hFF; dp = 2'b00; blank = 2'b00; lz_en = 1'b1;
    push("hold_no_load", 0, cyc + 2, {9'h0CF, 9'h000});
    step(3);

    // Mid-run asynchronous reset, then scan sequence with a load on a terminal-count edge.
    rst = 1'b1;
    push_reset("reset_mid");
    step(1);
    data = 8'h3A; dp = 2'b00; blank = 2'b00; blink = 2'b00; lz_en = 1'b0; load = 1'b1;
    rst = 1'b0;
    c0 = cyc;
    for (int k = 1; k <= 16; k++) begin
      push($sformatf("scan_dig_n_%0d", k), 1, c0 + k, {16'b0, DIG_TAB[k-1]});
      push($sformatf("scan_seg_%0d", k), 2, c0 + k, {10'b0, SCAN_TAB[k-1]});
    end
    step(1);
    load = 1'b0;
    step(6);
    data = 8'h9A; load = 1'b1;
    step(1);
    load = 1'b0;
    step(9);

    // Blink restart after reset: digit 0 alternates, digit 1 steady.
    rst = 1'b1;
    step(1);
    data = 8'h3A; dp = 2'b00; blank = 2'b00; blink = 2'b01; lz_en = 1'b0; load = 1'b1;
    rst = 1'b0;
    c0 = cyc;
    for (int k = 1; k <= 32; k++) begin
      push($sformatf("blink_%0d", k), 0, c0 + k,
           (k == 1) ? 18'h0 :
           ((((k - 1) / 8) % 2) == 0) ? {9'h04F, 9'h077} : {9'h04F, 9'h000});
    end
    step(1);
    load = 1'b0;
    step(33);

    fin_req = 1'b1;
    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
